// File: rtl/popcount_dispatcher.sv
// Feeds words from a ready/valid stream to the iterative popcount counter one at a time,
// buffering bursts in a small FIFO and abandoning an in-flight word if done never arrives.
module popcount_dispatcher #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = DATA_W + 4
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          data_val_i,
  output logic                          data_ready_o,
  output logic [DATA_W-1:0]             pc_data_o,
  output logic                          pc_data_val_o,
  input  logic                          pc_done_i,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   used_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  used_q;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_data_q, pc_data_d;
  logic              pc_val_q, pc_val_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timeout_q, timeout_d;

  logic push, pop;

  assign data_ready_o  = (used_q < CNT_W'(FIFO_DEPTH)) && !srst_i;
  assign push          = data_val_i && data_ready_o;
  assign used_o        = used_q;
  assign pc_data_o     = pc_data_q;
  assign pc_data_val_o = pc_val_q;
  assign busy_o        = (state_q == ST_WAIT);
  assign timeout_o     = timeout_q;

  // Storage needs no reset: pointers and occupancy define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   used_q <= used_q + CNT_W'(1);
        2'b01:   used_q <= used_q - CNT_W'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ST_IDLE;
      pc_data_q <= '0;
      pc_val_q  <= 1'b0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_data_q <= pc_data_d;
      pc_val_q  <= pc_val_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    pc_data_d = pc_data_q;
    pc_val_d  = 1'b0;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Occupancy is the registered value, so a word pushed this cycle waits a cycle.
        if (used_q != '0) begin
          pop       = 1'b1;
          pc_data_d = mem_q[rd_ptr_q];
          pc_val_d  = 1'b1;
          timer_d   = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timer_q < TMR_W'(TIMEOUT_CYC)) begin
          timer_d = timer_q + TMR_W'(1);
        end
        // Done in the strobe cycle is a stale pulse from the counter's idle toggling.
        if (pc_done_i && !pc_val_q) begin
          state_d = ST_IDLE;
        end else if (timer_d == TMR_W'(TIMEOUT_CYC)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_popcount_dispatcher.sv
// Directed bench for popcount_dispatcher with a behavioural counter that answers
// issue + 2 + popcount cycles after each strobe.
module tb_popcount_dispatcher;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        data_val_i = 1'b0;
  logic        data_ready_o;
  logic [15:0] pc_data_o;
  logic        pc_data_val_o;
  logic        pc_done_i = 1'b0;
  logic        busy_o;
  logic        timeout_o;
  logic [2:0]  used_o;

  popcount_dispatcher #(.DATA_W(16), .FIFO_DEPTH(4), .TIMEOUT_CYC(20)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .data_ready_o(data_ready_o), .pc_data_o(pc_data_o), .pc_data_val_o(pc_data_val_o),
    .pc_done_i(pc_done_i), .busy_o(busy_o), .timeout_o(timeout_o), .used_o(used_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] feed_q[$];
  int          acc_cyc[$];
  int          iss_cyc[$];
  logic [15:0] iss_dat[$];
  int          to_cyc[$];
  bit          busy_at[int];
  bit          busy_seen, full_seen, ready_full_seen;
  // mode 0: done held low, 1: counter model, 2: toggle every cycle, 3: fixed delay
  int          mode = 0;
  int          fixed_delay = 0;
  bit          pending = 0;
  int          done_at = 0;

  task automatic clear_logs();
    acc_cyc.delete(); iss_cyc.delete(); iss_dat.delete(); to_cyc.delete();
    busy_at.delete();
    busy_seen = 0; full_seen = 0; ready_full_seen = 0; pending = 0;
  endtask

  // Advances n cycles, feeding queued words and playing the counter's role.
  task automatic run(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      acc = data_val_i && data_ready_o;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk_i); #1; cyc++;
      if (acc) void'(feed_q.pop_front());
      if (pc_data_val_o) begin iss_cyc.push_back(cyc); iss_dat.push_back(pc_data_o); end
      if (timeout_o) to_cyc.push_back(cyc);
      busy_at[cyc] = busy_o;
      if (busy_o) busy_seen = 1;
      if (used_o == 3'd4) full_seen = 1;
      if (used_o == 3'd4 && data_ready_o) ready_full_seen = 1;
      if (mode == 2) pc_done_i = ~pc_done_i;
      else if (mode == 1 || mode == 3) begin
        pc_done_i = pending && (cyc == done_at);
        if (pc_done_i) pending = 0;
      end else pc_done_i = 1'b0;
      if (pc_data_val_o && (mode == 1 || mode == 3)) begin
        pending = 1;
        done_at = cyc + ((mode == 3) ? fixed_delay : 2 + $countones(pc_data_o));
      end
      if (feed_q.size() > 0) begin data_val_i = 1'b1; data_i = feed_q[0]; end
      else begin data_val_i = 1'b0; data_i = '0; end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      run(1);
      checks++;
      if ({data_ready_o, pc_data_val_o, busy_o, timeout_o, used_o, pc_data_o} !== 23'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got ready=%b val=%b busy=%b to=%b used=%0d data=%h, want all 0",
                 i, data_ready_o, pc_data_val_o, busy_o, timeout_o, used_o, pc_data_o);
      end
    end
    srst_i = 1'b0; #1;
    checks++;
    if (data_ready_o !== 1'b1) begin failures++; $display("FAIL ready_after_release: got %b want 1", data_ready_o); end
    checks++;
    if (used_o !== 3'd0 || pc_data_val_o !== 1'b0) begin
      failures++; $display("FAIL idle_after_release: got used=%0d val=%b want 0 0", used_o, pc_data_val_o);
    end
    clear_logs();
    run(5);
    checks++;
    if (iss_cyc.size() != 0) begin failures++; $display("FAIL no_issue_after_reset: got %0d issues want 0", iss_cyc.size()); end
  endtask

  task automatic test_single();
    int t;
    clear_logs(); mode = 1;
    feed_q.push_back(16'h00FF);
    run(20);
    checks++;
    if (iss_cyc.size() != 1 || acc_cyc.size() != 1) begin
      failures++; $display("FAIL single_count: got %0d issues %0d pushes want 1 1", iss_cyc.size(), acc_cyc.size());
    end else begin
      t = iss_cyc[0];
      checks++;
      if (iss_dat[0] !== 16'h00FF) begin failures++; $display("FAIL single_data: got %h want 00ff", iss_dat[0]); end
      checks++;
      if (t != acc_cyc[0] + 2) begin failures++; $display("FAIL single_latency: got %0d want %0d", t - acc_cyc[0], 2); end
      checks++;
      if (busy_at[t + 10] !== 1'b1 || busy_at[t + 11] !== 1'b0) begin
        failures++; $display("FAIL single_busy: got t+10=%b t+11=%b want 1 0", busy_at[t + 10], busy_at[t + 11]);
      end
    end
    checks++;
    if (to_cyc.size() != 0) begin failures++; $display("FAIL single_timeout: got %0d pulses want 0", to_cyc.size()); end
    checks++;
    if (pc_data_o !== 16'h00FF) begin failures++; $display("FAIL single_hold: got %h want 00ff", pc_data_o); end
  endtask

  task automatic test_burst();
    logic [15:0] words [6];
    int          gaps  [5];
    words = '{16'h0000, 16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'hFFFF};
    gaps  = '{4, 5, 6, 7, 8};
    clear_logs(); mode = 1;
    for (int i = 0; i < 6; i++) feed_q.push_back(words[i]);
    run(70);
    checks++;
    if (iss_cyc.size() != 6 || acc_cyc.size() != 6) begin
      failures++; $display("FAIL burst_count: got %0d issues %0d pushes want 6 6", iss_cyc.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (iss_dat[i] !== words[i]) begin failures++; $display("FAIL burst_data[%0d]: got %h want %h", i, iss_dat[i], words[i]); end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (iss_cyc[i + 1] - iss_cyc[i] != gaps[i]) begin
          failures++; $display("FAIL burst_gap[%0d]: got %0d want %0d", i, iss_cyc[i + 1] - iss_cyc[i], gaps[i]);
        end
      end
    end
    checks++;
    if (!full_seen || ready_full_seen) begin
      failures++; $display("FAIL burst_full: got full_seen=%b ready_when_full=%b want 1 0", full_seen, ready_full_seen);
    end
    checks++;
    if (to_cyc.size() != 0) begin failures++; $display("FAIL burst_timeout: got %0d pulses want 0", to_cyc.size()); end
  endtask

  task automatic test_idle_filter();
    clear_logs(); mode = 2;
    run(20);
    mode = 0;
    run(1);
    checks++;
    if (iss_cyc.size() != 0 || busy_seen) begin
      failures++; $display("FAIL idle_filter: got issues=%0d busy_seen=%b want 0 0", iss_cyc.size(), busy_seen);
    end
    checks++;
    if (used_o !== 3'd0) begin failures++; $display("FAIL idle_filter_used: got %0d want 0", used_o); end
  endtask

  task automatic test_watchdog();
    int t;
    clear_logs(); mode = 0;
    feed_q.push_back(16'h1234); feed_q.push_back(16'hABCD);
    run(50);
    checks++;
    if (iss_cyc.size() != 2 || to_cyc.size() != 2) begin
      failures++; $display("FAIL wd_counts: got %0d issues %0d timeouts want 2 2", iss_cyc.size(), to_cyc.size());
    end else begin
      t = iss_cyc[0];
      checks++;
      if (iss_dat[0] !== 16'h1234 || iss_dat[1] !== 16'hABCD) begin
        failures++; $display("FAIL wd_data: got %h %h want 1234 abcd", iss_dat[0], iss_dat[1]);
      end
      checks++;
      if (to_cyc[0] != t + 20) begin failures++; $display("FAIL wd_fire: got +%0d want +20", to_cyc[0] - t); end
      checks++;
      if (iss_cyc[1] != t + 21) begin failures++; $display("FAIL wd_next_issue: got +%0d want +21", iss_cyc[1] - t); end
      checks++;
      if (to_cyc[1] != t + 41) begin failures++; $display("FAIL wd_single_pulse: got second at +%0d want +41", to_cyc[1] - t); end
      checks++;
      if (busy_at[t + 19] !== 1'b1 || busy_at[t + 20] !== 1'b0) begin
        failures++; $display("FAIL wd_busy: got t+19=%b t+20=%b want 1 0", busy_at[t + 19], busy_at[t + 20]);
      end
    end
  endtask

  task automatic test_done_priority();
    clear_logs(); mode = 3; fixed_delay = 19;
    feed_q.push_back(16'h5555); feed_q.push_back(16'h0F0F);
    run(50);
    mode = 0;
    run(1);
    checks++;
    if (to_cyc.size() != 0) begin failures++; $display("FAIL prio_timeout: got %0d pulses want 0", to_cyc.size()); end
    checks++;
    if (iss_cyc.size() != 2) begin
      failures++; $display("FAIL prio_count: got %0d issues want 2", iss_cyc.size());
    end else if (iss_cyc[1] - iss_cyc[0] != 21) begin
      failures++; $display("FAIL prio_spacing: got %0d want 21", iss_cyc[1] - iss_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs(); mode = 1;
    feed_q.push_back(16'hFFFF); feed_q.push_back(16'h0001);
    feed_q.push_back(16'h0002); feed_q.push_back(16'h0003);
    run(6);
    checks++;
    if (used_o !== 3'd3 || busy_o !== 1'b1) begin
      failures++; $display("FAIL mid_pre_state: got used=%0d busy=%b want 3 1", used_o, busy_o);
    end
    srst_i = 1'b1;
    run(1);
    checks++;
    if (used_o !== 3'd0 || busy_o !== 1'b0 || pc_data_val_o !== 1'b0 || data_ready_o !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got used=%0d busy=%b val=%b ready=%b want 0 0 0 0",
                           used_o, busy_o, pc_data_val_o, data_ready_o);
    end
    srst_i = 1'b0;
    run(1);
    checks++;
    if (pc_data_val_o !== 1'b0 || used_o !== 3'd0) begin
      failures++; $display("FAIL mid_after: got val=%b used=%0d want 0 0", pc_data_val_o, used_o);
    end
    run(30);
    checks++;
    if (iss_cyc.size() != 1) begin failures++; $display("FAIL mid_discard: got %0d issues want 1", iss_cyc.size()); end
    feed_q.push_back(16'h00A5);
    run(20);
    checks++;
    if (iss_cyc.size() != 2) begin
      failures++; $display("FAIL mid_new_count: got %0d issues want 2", iss_cyc.size());
    end else begin
      checks++;
      if (iss_dat[1] !== 16'h00A5 || iss_cyc[1] != acc_cyc[acc_cyc.size() - 1] + 2) begin
        failures++; $display("FAIL mid_new_issue: got data=%h latency=%0d want 00a5 2",
                             iss_dat[1], iss_cyc[1] - acc_cyc[acc_cyc.size() - 1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_idle_filter();
    test_watchdog();
    test_done_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/popcount_dispatcher.md
Name: popcount_dispatcher

Overview:
- Upstream feeder for the iterative bit population counter.
- Accepts a ready/valid word stream and buffers bursts in a small FIFO.
- Issues one word at a time to the counter as a single-cycle data_val pulse, then waits for the counter's completion pulse before issuing the next.
- Provides a watchdog so a lost completion pulse cannot stall the pipeline.

Parameters:
- DATA_W, 16, word width; must match the counter's DATA_W.
- FIFO_DEPTH, 4, buffer entries; power of two, >= 2.
- TIMEOUT_CYC, DATA_W+4, maximum WAIT cycles before the in-flight word is abandoned.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous active-high reset.
- data_i  in  DATA_W  input word.
- data_val_i  in  1  input word valid.
- data_ready_o  out  1  FIFO can accept a word.
- pc_data_o  out  DATA_W  word presented to the counter.
- pc_data_val_o  out  1  single-cycle issue strobe to the counter.
- pc_done_i  in  1  counter completion strobe (the counter's data_val_o).
- busy_o  out  1  a word is in flight (state WAIT).
- timeout_o  out  1  one-cycle pulse when the watchdog fires.
- used_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk_i. srst_i is synchronous, active-high.
- Reset values:
  - FIFO emptied; used_o=0.
  - State IDLE.
  - pc_data_o=0, pc_data_val_o=0, busy_o=0, timeout_o=0, timer=0.
  - data_ready_o=0 while srst_i=1.
- Reset mid-operation:
  - The in-flight word and all buffered words are discarded.
  - No pc_data_val_o pulse is produced in the reset cycle or the cycle after.
- Input handshake:
  - Push occurs when data_val_i && data_ready_o.
  - data_ready_o = (used_o < FIFO_DEPTH) && !srst_i.
  - There is no full-bypass: when full, ready stays low even if a pop happens in the same cycle.
  - data_i is ignored when data_val_i=0.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Simultaneous push and pop leaves used_o unchanged.
  - Data order is preserved.
- FSM, IDLE:
  - If the FIFO is non-empty, pop the head and register pc_data_o<=head and pc_data_val_o<=1.
  - Clear timer, then go to WAIT.
  - A word pushed this cycle into an empty FIFO is not issued this cycle; it is issued at the earliest next cycle.
- FSM, WAIT:
  - pc_data_val_o deasserts after exactly one cycle.
  - timer increments every cycle and saturates at TIMEOUT_CYC.
  - busy_o=1.
  - pc_done_i is ignored in the cycle pc_data_val_o=1.
  - In any later WAIT cycle, pc_done_i=1 returns the FSM to IDLE.
  - If timer reaches TIMEOUT_CYC with no accepted done: pulse timeout_o for one cycle, drop the word, and return to IDLE.
- pc_done_i outside WAIT:
  - Ignored.
  - The counter toggles its valid while idle, so these pulses must be filtered out.
- Issue timing:
  - Issue strobe visible at cycle t; the counter asserts done at t+2+k, where k is the popcount of the issued word.
  - The FSM returns to IDLE at t+3+k.
  - The next strobe is visible at t+4+k.
  - Minimum issue spacing is therefore 4 cycles.
- pc_data_o holds the last issued word until the next issue.
- Timeout and done in the same cycle: done takes priority, and timeout_o stays 0.

Test Plan:
- Reset check: assert srst_i 3 cycles, then release.
  - Required: all outputs 0 during reset.
  - Required: data_ready_o=1 the first cycle after release; used_o=0; no pc_data_val_o.
- Single word 0x00FF with a counter model (done at issue+2+popcount):
  - Required: one pc_data_val_o pulse with pc_data_o=0x00FF.
  - Required: busy_o high 10 cycles from issue, then IDLE; timeout_o never asserts.
- Burst of 6 words 0x0000,0x0001,0x0003,0x0007,0x000F,0xFFFF at DEPTH=4, presented back-to-back:
  - Required: data_ready_o drops once used_o=4.
  - Required: all 6 words are issued in order with spacing 4,5,6,7,8 cycles.
  - Required: no word lost or duplicated.
- Idle done filtering: FIFO empty, toggle pc_done_i every cycle for 20 cycles.
  - Required: state stays IDLE; no issue; busy_o=0.
- Watchdog: issue 0x1234 with pc_done_i held 0.
  - Required: timeout_o pulses exactly once, TIMEOUT_CYC=20 cycles after the issue strobe.
  - Required: the FSM returns to IDLE and the next queued word is issued 1 cycle later.
- Reset mid-WAIT with 3 words queued: assert srst_i for 1 cycle.
  - Required: used_o=0, busy_o=0.
  - Required: none of the queued words is ever issued.
  - Required: a new word pushed afterwards issues normally.
